// File: rtl/spi_bus_bridge_pkg.sv
// rtl/spi_bus_bridge_pkg.sv - shared types and constants for the SPI register bridge
package spi_bus_bridge_pkg;

  // SPI mode encodings for the CPOL / CPHA parameters
  localparam int CPOL_IDLE_LOW  = 0;
  localparam int CPOL_IDLE_HIGH = 1;
  localparam int CPHA_LEAD      = 0;
  localparam int CPHA_TRAIL     = 1;

  // Bit-counter width, wide enough for a 32-bit word or a 16-bit header
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
  } state_e;

  // The read/write flag sits just above the address bits of the header
  function automatic int hdr_rw_pos(input int aw);
    return aw;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - SPI pin synchroniser with sample/shift edge pulses
module spi_sync_edge
  import spi_bus_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sclk,
  input  logic i_mosi,
  input  logic i_ncs,
  output logic o_mosi,
  output logic o_ncs,
  output logic o_sample,
  output logic o_shift
);

  localparam logic L_SCLK_IDLE = (CPOL == CPOL_IDLE_HIGH);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic                   r_sclk_d;
  logic                   w_sclk;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_lead;
  logic                   w_trail;

  // Synchronise the pins; nCS resets low so the bridge must see it high before a frame
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclk_sync <= {SYNC_STAGES{L_SCLK_IDLE}};
      r_mosi_sync <= '0;
      r_ncs_sync  <= '0;
      r_sclk_d    <= L_SCLK_IDLE;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], i_ncs};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk   = r_sclk_sync[SYNC_STAGES-1];
  assign w_rise   = w_sclk & ~r_sclk_d;
  assign w_fall   = ~w_sclk & r_sclk_d;
  assign w_lead   = (CPOL == CPOL_IDLE_HIGH) ? w_fall : w_rise;
  assign w_trail  = (CPOL == CPOL_IDLE_HIGH) ? w_rise : w_fall;
  assign o_sample = (CPHA == CPHA_TRAIL) ? w_trail : w_lead;
  assign o_shift  = (CPHA == CPHA_TRAIL) ? w_lead : w_trail;
  assign o_mosi   = r_mosi_sync[SYNC_STAGES-1];
  assign o_ncs    = r_ncs_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_bus_bridge.sv
// rtl/spi_bus_bridge.sv - SPI slave bridging a host to the internal register bus
module spi_bus_bridge
  import spi_bus_bridge_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_sclk,
  input  logic          i_mosi,
  input  logic          i_ncs,
  output logic          o_miso,
  output logic          o_miso_oe,
  output logic          o_wr_stb,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_rd_req,
  output logic [AW-1:0] o_rd_addr,
  input  logic          i_rd_ack,
  input  logic [DW-1:0] i_rd_data,
  output logic          o_busy,
  output logic          o_err
);

  localparam int               RW_POS      = hdr_rw_pos(AW);
  localparam logic [AW-1:0]    L_INC       = (AUTO_INC != 0) ? AW'(1) : AW'(0);
  localparam logic [CNT_W-1:0] L_HDR_LAST  = CNT_W'(AW);
  localparam logic [CNT_W-1:0] L_WORD_LAST = CNT_W'(DW - 1);

  logic             w_mosi;
  logic             w_ncs;
  logic             w_sample;
  logic             w_shift;
  logic [AW:0]      w_hdr_next;
  logic [DW-1:0]    w_word_next;
  logic [AW-1:0]    w_addr_next;
  logic             w_ack;

  state_e           r_state;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    r_hdr;
  logic             r_rw;
  logic [AW-1:0]    r_addr;
  logic [DW-2:0]    r_shift;
  logic [DW-1:0]    r_pref;
  logic             r_pref_vld;
  logic             r_load_pend;
  logic             r_miso;
  logic             r_miso_oe;
  logic             r_wr_stb;
  logic [AW-1:0]    r_wr_addr;
  logic [DW-1:0]    r_wr_data;
  logic             r_rd_req;
  logic [AW-1:0]    r_rd_addr;
  logic             r_busy;
  logic             r_err;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .CPOL        (CPOL),
    .CPHA        (CPHA)
  ) u_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_sclk   (i_sclk),
    .i_mosi   (i_mosi),
    .i_ncs    (i_ncs),
    .o_mosi   (w_mosi),
    .o_ncs    (w_ncs),
    .o_sample (w_sample),
    .o_shift  (w_shift)
  );

  // r_shift keeps only DW-1 bits: the MSB is always already on MISO or about to be captured
  assign w_hdr_next  = {r_hdr, w_mosi};
  assign w_word_next = {r_shift, w_mosi};
  assign w_addr_next = r_addr + L_INC;
  assign w_ack       = i_rd_ack & r_rd_req;

  // Frame FSM: header decode, write word assembly, read prefetch and MISO shifting
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_armed     <= 1'b0;
      r_cnt       <= '0;
      r_hdr       <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_shift     <= '0;
      r_pref      <= '0;
      r_pref_vld  <= 1'b0;
      r_load_pend <= 1'b0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wr_stb <= 1'b0;
      r_err    <= 1'b0;
      if (w_ncs) r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_miso    <= 1'b0;
          r_miso_oe <= 1'b0;
          r_busy    <= 1'b0;
          r_rd_req  <= 1'b0;
          if (r_armed && !w_ncs) begin
            r_state     <= ST_HDR;
            r_busy      <= 1'b1;
            r_miso_oe   <= 1'b1;
            r_cnt       <= '0;
            r_hdr       <= '0;
            r_load_pend <= 1'b0;
            r_pref_vld  <= 1'b0;
          end
        end
        ST_HDR: begin
          if (w_sample) begin
            r_hdr <= w_hdr_next[AW-1:0];
            if (r_cnt == L_HDR_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_DATA;
              r_rw    <= w_hdr_next[RW_POS];
              r_addr  <= w_hdr_next[AW-1:0];
              if (w_hdr_next[RW_POS]) begin
                r_rd_req    <= 1'b1;
                r_rd_addr   <= w_hdr_next[AW-1:0];
                r_load_pend <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_ack) begin
            r_pref     <= i_rd_data;
            r_pref_vld <= 1'b1;
            r_rd_req   <= 1'b0;
          end
          if (w_sample) begin
            if (!r_rw) r_shift <= w_word_next[DW-2:0];
            if (r_cnt == L_WORD_LAST) begin
              r_cnt <= '0;
              if (r_rw) begin
                r_load_pend <= 1'b1;
              end else begin
                r_wr_stb  <= 1'b1;
                r_wr_addr <= r_addr;
                r_wr_data <= w_word_next;
                r_addr    <= w_addr_next;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          if (w_shift && r_rw) begin
            if (r_load_pend) begin
              r_load_pend <= 1'b0;
              if (r_pref_vld) begin
                r_shift    <= r_pref[DW-2:0];
                r_miso     <= r_pref[DW-1];
                r_pref_vld <= 1'b0;
                r_addr     <= w_addr_next;
                r_rd_addr  <= w_addr_next;
                r_rd_req   <= 1'b1;
              end else begin
                // Underrun: send zeros, keep the outstanding request for the next word
                r_shift <= '0;
                r_miso  <= 1'b0;
                r_err   <= 1'b1;
              end
            end else begin
              r_shift <= {r_shift[DW-3:0], 1'b0};
              r_miso  <= r_shift[DW-2];
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // nCS release aborts the frame but lets a word completing this cycle still strobe
      if (r_state != ST_IDLE && w_ncs) begin
        r_state   <= ST_IDLE;
        r_rd_req  <= 1'b0;
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
        r_busy    <= 1'b0;
      end
    end
  end

  assign o_miso    = r_miso;
  assign o_miso_oe = r_miso_oe;
  assign o_wr_stb  = r_wr_stb;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_rd_req  = r_rd_req;
  assign o_rd_addr = r_rd_addr;
  assign o_busy    = r_busy;
  assign o_err     = r_err;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// tb/tb_spi_bus_bridge.sv - directed bench for spi_bus_bridge across four SPI configurations
module tb_spi_bus_bridge;

  localparam int HALF = 8;
  localparam int P_CPOL [4] = '{0, 1, 0, 0};
  localparam int P_CPHA [4] = '{0, 1, 1, 0};
  localparam int P_INC  [4] = '{1, 1, 1, 0};

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk_raw;
  logic        mosi;
  logic [3:0]  ncs;
  logic [3:0]  miso, miso_oe, wr_stb, rd_req, busy, err;
  logic [3:0]  rd_ack;
  logic [7:0]  wr_addr [4];
  logic [7:0]  rd_addr [4];
  logic [15:0] wr_data [4];
  logic [15:0] rd_data [4];

  int          n_cmp = 0;
  int          n_fail = 0;
  int          wr_n [4];
  int          err_n [4];
  int          miso_hi_n [4];
  int          busy_hi_n [4];
  int          ra_n [4];
  int          ack_cnt [4];
  int          ack_delay [4];
  int          rd_idx [4];
  logic        req_prev [4];
  logic [7:0]  wr_la [4][16];
  logic [15:0] wr_ld [4][16];
  logic [7:0]  ra_log [4][16];
  logic [15:0] rd_tbl [4][8];

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 4; g++) begin : g_dut
    spi_bus_bridge #(
      .DW (16), .AW (8), .CPOL (P_CPOL[g]), .CPHA (P_CPHA[g]),
      .SYNC_STAGES (2), .AUTO_INC (P_INC[g])
    ) u_dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_sclk    ((P_CPOL[g] != 0) ? ~sclk_raw : sclk_raw),
      .i_mosi    (mosi),
      .i_ncs     (ncs[g]),
      .o_miso    (miso[g]),
      .o_miso_oe (miso_oe[g]),
      .o_wr_stb  (wr_stb[g]),
      .o_wr_addr (wr_addr[g]),
      .o_wr_data (wr_data[g]),
      .o_rd_req  (rd_req[g]),
      .o_rd_addr (rd_addr[g]),
      .i_rd_ack  (rd_ack[g]),
      .i_rd_data (rd_data[g]),
      .o_busy    (busy[g]),
      .o_err     (err[g])
    );
  end

  // Bus-side monitor and read responder
  initial begin
    rd_ack = '0;
    for (int i = 0; i < 4; i++) begin
      rd_data[i] = '0; wr_n[i] = 0; err_n[i] = 0; miso_hi_n[i] = 0; busy_hi_n[i] = 0;
      ra_n[i] = 0; ack_cnt[i] = 0; ack_delay[i] = 3; rd_idx[i] = 0; req_prev[i] = 1'b0;
      for (int k = 0; k < 8; k++) rd_tbl[i][k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (wr_stb[i] && wr_n[i] < 16) begin
          wr_la[i][wr_n[i]] = wr_addr[i];
          wr_ld[i][wr_n[i]] = wr_data[i];
        end
        if (wr_stb[i]) wr_n[i]++;
        if (err[i]) err_n[i]++;
        if (miso[i]) miso_hi_n[i]++;
        if (busy[i]) busy_hi_n[i]++;
        if (rd_req[i] && !req_prev[i]) begin
          if (ra_n[i] < 16) ra_log[i][ra_n[i]] = rd_addr[i];
          ra_n[i]++;
        end
        req_prev[i] = rd_req[i];
        rd_ack[i] = 1'b0;
        if (rd_req[i]) begin
          ack_cnt[i]++;
          if (ack_cnt[i] == ack_delay[i]) begin
            rd_ack[i]  = 1'b1;
            rd_data[i] = rd_tbl[i][rd_idx[i]];
            rd_idx[i]  = (rd_idx[i] + 1) % 8;
            ack_cnt[i] = 0;
          end
        end else begin
          ack_cnt[i] = 0;
        end
      end
    end
  end

  task automatic spi_xfer(input int inst, input int cpha, input int nbits,
                          input logic [63:0] tx, output logic [63:0] rx);
    rx = '0;
    for (int b = nbits - 1; b >= 0; b--) begin
      if (cpha == 0) begin
        mosi = tx[b];
        repeat (HALF) @(negedge clk);
        rx[b] = miso[inst];
        sclk_raw = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk_raw = 1'b0;
      end else begin
        sclk_raw = 1'b1;
        mosi = tx[b];
        repeat (HALF) @(negedge clk);
        rx[b] = miso[inst];
        sclk_raw = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_begin(input int inst);
    ncs[inst] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end(input int inst);
    repeat (6) @(negedge clk);
    ncs[inst] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [41:0] obs;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      obs = {miso[i], miso_oe[i], wr_stb[i], rd_req[i], busy[i], err[i], wr_addr[i], wr_data[i], rd_addr[i]};
      n_cmp++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs inst%0d got %h expected 0", i, obs);
      end
    end
  endtask

  task automatic test_write_mode0();
    logic [63:0] rx;
    int base, mh;
    base = wr_n[0]; mh = miso_hi_n[0];
    frame_begin(0);
    spi_xfer(0, 0, 41, 64'({9'h012, 16'hBEEF, 16'h1234}), rx);
    frame_end(0);
    n_cmp++;
    if (wr_n[0] - base !== 2) begin n_fail++; $display("FAIL wr_count got %0d expected 2", wr_n[0] - base); end
    n_cmp++;
    if ({wr_la[0][base], wr_ld[0][base]} !== 24'h12BEEF) begin
      n_fail++; $display("FAIL wr_word0 got %h expected 12beef", {wr_la[0][base], wr_ld[0][base]});
    end
    n_cmp++;
    if ({wr_la[0][base+1], wr_ld[0][base+1]} !== 24'h131234) begin
      n_fail++; $display("FAIL wr_word1 got %h expected 131234", {wr_la[0][base+1], wr_ld[0][base+1]});
    end
    n_cmp++;
    if (miso_hi_n[0] - mh !== 0) begin n_fail++; $display("FAIL wr_miso_zero got %0d high cycles expected 0", miso_hi_n[0] - mh); end
  endtask

  task automatic test_read_mode3_wrap();
    logic [63:0] rx;
    int rb, eb;
    rb = ra_n[1]; eb = err_n[1];
    ack_delay[1] = 3;
    rd_tbl[1][rd_idx[1]]           = 16'hA5A5;
    rd_tbl[1][(rd_idx[1] + 1) % 8] = 16'h5A5A;
    rd_tbl[1][(rd_idx[1] + 2) % 8] = 16'hFFFF;
    frame_begin(1);
    spi_xfer(1, 1, 41, 64'({9'h1FF, 32'h0}), rx);
    frame_end(1);
    n_cmp++;
    if (rx[31:0] !== 32'hA5A55A5A) begin n_fail++; $display("FAIL rd3_miso got %h expected a5a55a5a", rx[31:0]); end
    n_cmp++;
    if (ra_log[1][rb] !== 8'hFF) begin n_fail++; $display("FAIL rd3_addr0 got %h expected ff", ra_log[1][rb]); end
    n_cmp++;
    if (ra_log[1][rb+1] !== 8'h00) begin n_fail++; $display("FAIL rd3_addr1_wrap got %h expected 00", ra_log[1][rb+1]); end
    n_cmp++;
    if (err_n[1] - eb !== 0) begin n_fail++; $display("FAIL rd3_err got %0d expected 0", err_n[1] - eb); end
  endtask

  task automatic test_read_underrun();
    logic [63:0] rx;
    int eb;
    eb = err_n[2];
    ack_delay[2] = 12;
    for (int k = 0; k < 8; k++) rd_tbl[2][k] = 16'hC3C3;
    frame_begin(2);
    spi_xfer(2, 1, 41, 64'({9'h110, 32'h0}), rx);
    frame_end(2);
    n_cmp++;
    if (rx[31:16] !== 16'h0000) begin n_fail++; $display("FAIL underrun_word0 got %h expected 0000", rx[31:16]); end
    n_cmp++;
    if (rx[15:0] !== 16'hC3C3) begin n_fail++; $display("FAIL underrun_word1 got %h expected c3c3", rx[15:0]); end
    n_cmp++;
    if (err_n[2] - eb !== 1) begin n_fail++; $display("FAIL underrun_err got %0d pulses expected 1", err_n[2] - eb); end
  endtask

  task automatic test_abort();
    logic [63:0] rx;
    int base;
    base = wr_n[0];
    frame_begin(0);
    spi_xfer(0, 0, 18, 64'({9'h020, 9'h155}), rx);
    n_cmp++;
    if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL abort_busy_mid got %b expected 1", busy[0]); end
    frame_end(0);
    n_cmp++;
    if (wr_n[0] - base !== 0) begin n_fail++; $display("FAIL abort_no_stb got %0d expected 0", wr_n[0] - base); end
    n_cmp++;
    if ({busy[0], miso_oe[0]} !== 2'b00) begin n_fail++; $display("FAIL abort_idle got %b expected 00", {busy[0], miso_oe[0]}); end
    frame_begin(0);
    spi_xfer(0, 0, 25, 64'({9'h030, 16'hCAFE}), rx);
    frame_end(0);
    n_cmp++;
    if (wr_n[0] - base !== 1) begin n_fail++; $display("FAIL abort_next_count got %0d expected 1", wr_n[0] - base); end
    n_cmp++;
    if ({wr_la[0][base], wr_ld[0][base]} !== 24'h30CAFE) begin
      n_fail++; $display("FAIL abort_next_word got %h expected 30cafe", {wr_la[0][base], wr_ld[0][base]});
    end
  endtask

  task automatic test_reset_mid_read();
    logic [63:0] rx;
    logic [41:0] obs;
    int wb, bb, rb;
    for (int k = 0; k < 8; k++) rd_tbl[0][k] = 16'h1357;
    ack_delay[0] = 3;
    frame_begin(0);
    spi_xfer(0, 0, 14, 64'({9'h155, 5'h0}), rx);
    rst = 1'b1;
    @(negedge clk);
    obs = {miso[0], miso_oe[0], wr_stb[0], rd_req[0], busy[0], err[0], wr_addr[0], wr_data[0], rd_addr[0]};
    n_cmp++;
    if (obs !== '0) begin n_fail++; $display("FAIL rst_mid_outputs got %h expected 0", obs); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wb = wr_n[0]; bb = busy_hi_n[0];
    spi_xfer(0, 0, 25, 64'({9'h030, 16'hFFFF}), rx);
    n_cmp++;
    if (busy_hi_n[0] - bb !== 0) begin n_fail++; $display("FAIL rst_held_busy got %0d cycles expected 0", busy_hi_n[0] - bb); end
    n_cmp++;
    if (wr_n[0] - wb !== 0) begin n_fail++; $display("FAIL rst_held_stb got %0d expected 0", wr_n[0] - wb); end
    ncs[0] = 1'b1;
    repeat (8) @(negedge clk);
    rb = ra_n[0];
    frame_begin(0);
    spi_xfer(0, 0, 25, 64'({9'h155, 16'h0}), rx);
    frame_end(0);
    n_cmp++;
    if (rx[15:0] !== 16'h1357) begin n_fail++; $display("FAIL rst_new_read got %h expected 1357", rx[15:0]); end
    n_cmp++;
    if (ra_log[0][rb] !== 8'h55) begin n_fail++; $display("FAIL rst_new_addr got %h expected 55", ra_log[0][rb]); end
  endtask

  task automatic test_no_autoinc();
    logic [63:0] rx;
    int base;
    base = wr_n[3];
    frame_begin(3);
    spi_xfer(3, 0, 57, 64'({9'h040, 16'h1111, 16'h2222, 16'h3333}), rx);
    frame_end(3);
    n_cmp++;
    if (wr_n[3] - base !== 3) begin n_fail++; $display("FAIL noinc_count got %0d expected 3", wr_n[3] - base); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({wr_la[3][base+k], wr_ld[3][base+k]} !== {8'h40, {4{4'(k + 1)}}}) begin
        n_fail++;
        $display("FAIL noinc_word%0d got %h expected %h", k, {wr_la[3][base+k], wr_ld[3][base+k]}, {8'h40, {4{4'(k + 1)}}});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sclk_raw = 1'b0;
    mosi = 1'b0;
    ncs = 4'hF;
    test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    test_write_mode0();
    test_read_mode3_wrap();
    test_read_underrun();
    test_abort();
    test_reset_mid_read();
    test_no_autoinc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
